// File: rtl/step_counter_gen2.sv
// Programmable up/down step counter with prescaled tick, load, overflow pulse and previous-value monitor.
// Optional build macro STEP_COUNTER_SAT_EN: saturate at the range limits instead of wrapping.
module step_counter_gen2 #(
    parameter int WIDTH    = 8,
    parameter int DIVW     = 26,
    parameter int DIV_SLOW = 50000000,
    parameter int DIV_FAST = 5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             speed,
    input  logic             dir,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] monitor_signal,
    output logic             tick,
    output logic             ovf
);

    localparam logic [DIVW-1:0] TERM_SLOW = DIVW'(DIV_SLOW - 1);
    localparam logic [DIVW-1:0] TERM_FAST = DIVW'(DIV_FAST - 1);
    localparam logic [DIVW-1:0] DIV_ONE   = {{(DIVW-1){1'b0}}, 1'b1};

    logic [DIVW-1:0]  div_cnt_r;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] monitor_r;
    logic             ovf_r;
    logic [DIVW-1:0]  term_s;
    logic             tick_s;
    logic [WIDTH:0]   step_res_s;

    // Result bit WIDTH carries the carry/borrow flag; lower bits hold the new count.
    function automatic logic [WIDTH:0] step_result(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] amt,
        input logic             down
    );
        logic [WIDTH:0] raw;
        raw = down ? ({1'b0, cur} - {1'b0, amt}) : ({1'b0, cur} + {1'b0, amt});
`ifdef STEP_COUNTER_SAT_EN
        raw[WIDTH-1:0] = raw[WIDTH] ? (down ? {WIDTH{1'b0}} : {WIDTH{1'b1}}) : raw[WIDTH-1:0];
`endif
        return raw;
    endfunction

    // Tick decode; >= lets a rate change below the current prescaler value tick at once.
    always_comb begin
        term_s     = speed ? TERM_FAST : TERM_SLOW;
        tick_s     = en & ~load & (div_cnt_r >= term_s);
        step_res_s = step_result(count_r, step, dir);
    end

    // Prescaler, counter, monitor and overflow state; load outranks tick and ignores en.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= {DIVW{1'b0}};
            count_r   <= {WIDTH{1'b0}};
            monitor_r <= {WIDTH{1'b0}};
            ovf_r     <= 1'b0;
        end else if (load) begin
            div_cnt_r <= {DIVW{1'b0}};
            count_r   <= value;
            monitor_r <= count_r;
            ovf_r     <= 1'b0;
        end else if (tick_s) begin
            div_cnt_r <= {DIVW{1'b0}};
            count_r   <= step_res_s[WIDTH-1:0];
            monitor_r <= count_r;
            ovf_r     <= step_res_s[WIDTH];
        end else if (en) begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
            ovf_r     <= 1'b0;
        end else begin
            ovf_r     <= 1'b0;
        end
    end

    assign count          = count_r;
    assign monitor_signal = monitor_r;
    assign tick           = tick_s;
    assign ovf            = ovf_r;

endmodule
